// File: rtl/circuit_ctrl_pkg.sv
// Shared types and constants for the exhaustive AND-OR circuit sweep controller.
package circuit_ctrl_pkg;
  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;
  // Golden truth table of F=(A&B)|C, bit i is F for vector i = {A,B,C}
  localparam logic [NUM_VEC-1:0] DEFAULT_TT = 8'hEA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;
endpackage

// File: rtl/circuit_sweep_ctrl.sv
// Drives all 8 {A,B,C} vectors into an external datapath, samples F after a
// settle delay, and compares the captured truth table against a golden one.
module circuit_sweep_ctrl
  import circuit_ctrl_pkg::*;
#(
  parameter int unsigned         SETTLE      = 1,
  parameter logic [NUM_VEC-1:0]  EXPECTED_TT = DEFAULT_TT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               f,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [3:0]         err_cnt,
  output logic [NUM_VEC-1:0] tt_out
);

  localparam logic [3:0]       SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [VEC_W-1:0] LAST_VEC  = VEC_W'(NUM_VEC - 1);

  state_t           state;
  logic [VEC_W-1:0] vec;
  logic [3:0]       cnt;

  assign {a, b, c} = vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      vec     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
      tt_out  <= '0;
    end else begin
      done <= 1'b0;
      // Abort drops straight back to IDLE; results keep their partial values.
      if (state != ST_IDLE && abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              vec     <= '0;
              cnt     <= '0;
              tt_out  <= '0;
              err_cnt <= '0;
              pass    <= 1'b0;
              busy    <= 1'b1;
              state   <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (cnt < SETTLE_M1) cnt <= cnt + 4'd1;
            else                 state <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            tt_out[vec] <= f;
            if (f != EXPECTED_TT[vec]) err_cnt <= err_cnt + 4'd1;
            if (vec != LAST_VEC) begin
              vec   <= vec + VEC_W'(1);
              cnt   <= '0;
              state <= ST_SETTLE;
            end else begin
              state <= ST_DONE;
            end
          end
          ST_DONE: begin
            done  <= 1'b1;
            pass  <= (err_cnt == 4'd0);
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
